divacc: RTL

//   Iterative divide-accumulator; the inverse of the multiply-accumulate

---
 rtl/divacc.sv | 110 +++++++++++
 1 files changed

// File: rtl/divacc.sv
// Iterative restoring divide-accumulator: acc <= acc / x per accepted request.
// Ports: clk, reset, en, x in; out(=acc), rem, busy, done, div_zero, inexact out.
module divacc #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rem,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             inexact
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] p;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0] p_sh;
  logic [WIDTH:0] p_nx;
  logic           ge;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: if (en) state_n = (x == '0) ? S_DONE : S_DIV;
      S_DIV:  if (cnt == CW'(1)) state_n = S_DONE;
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Partial remainder stays below the divisor, so WIDTH bits hold it;
  // only the shifted compare needs the extra bit.
  always_comb begin
    p_sh = {p, dvd[WIDTH-1]};
    ge   = (p_sh >= {1'b0, dvs});
    p_nx = ge ? (p_sh - {1'b0, dvs}) : p_sh;
  end

  // Quotient bits shift into the dividend register from the LSB side.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= INIT;
      rem_q    <= '0;
      dvs      <= '0;
      dvd      <= '0;
      p        <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      inexact  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (en) begin
            dvd <= acc;
            p   <= '0;
            if (x == '0) begin
              div_zero <= 1'b1;
            end else begin
              dvs <= x;
              cnt <= CW'(WIDTH);
            end
          end
        end
        S_DIV: begin
          p   <= p_nx[WIDTH-1:0];
          dvd <= {dvd[WIDTH-2:0], ge};
          cnt <= cnt - CW'(1);
        end
        S_DONE: begin
          acc     <= dvd;
          rem_q   <= p;
          inexact <= inexact | (p != '0);
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out  = acc;
  assign rem  = rem_q;
  assign busy = (state != S_IDLE);

endmodule
